// File: rtl/jk_arb_pkg.sv
// jk_arb_pkg: shared FSM state type and JK command encodings for jk_reg_arbiter.
//   state_t : IDLE (waiting for a request), APPLY (register update), RESP (answer handshake)
//   OP_*    : {J,K} command encodings applied to each masked register bit
package jk_arb_pkg;

    typedef enum logic [1:0] {IDLE, APPLY, RESP} state_t;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; the search starts at ptr and wraps.
//   req   in  N_REQ  request vector
//   ptr   in  IDW    highest-priority index for this search
//   grant out N_REQ  one-hot grant (zero when no request)
//   idx   out IDW    encoded winner index
//   any   out 1      at least one request present
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   idx,
    output logic             any
);

    // Walk offsets from farthest to nearest so the nearest requester at or after ptr wins last.
    always_comb begin
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N_REQ]) idx = IDW'((int'(ptr) + i) % N_REQ);
        end
        any   = |req;
        grant = any ? N_REQ'(1) << idx : '0;
    end

endmodule

// File: rtl/jk_reg_arbiter.sv
// jk_reg_arbiter: round-robin shared JK register bank; one command per grant, answered by a response handshake.
//   clk, rst (sync, active-low)
//   req_valid/req_ready  per-requester command handshake (ready one-hot)
//   req_op   {J,K} per requester at [2i+1:2i];  req_mask WIDTH bits per requester
//   resp_valid/resp_ready, resp_id, resp_q  answer carrying the updated register value
//   q     live register contents;  busy  FSM not idle
module jk_reg_arbiter
    import jk_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [2*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_mask,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [WIDTH-1:0]       resp_q,
    output logic [WIDTH-1:0]       q,
    output logic                   busy
);

    state_t           state, state_nx;
    logic [IDW-1:0]   ptr, id_r, win;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] mask_r, q_nx;
    logic [N_REQ-1:0] grant;
    logic             any;

    rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win),
        .any   (any)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE  ? (any ? APPLY : IDLE) :
                   state == APPLY ? RESP :
                   state == RESP  ? (resp_ready ? IDLE : RESP) : IDLE;
    end

    // Ready is gated by rst so no acceptance is signalled while reset is held.
    always_comb begin
        req_ready  = (rst && state == IDLE) ? grant : '0;
        resp_valid = state == RESP;
        resp_id    = resp_valid ? id_r : '0;
        resp_q     = resp_valid ? q : '0;
        busy       = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr    <= '0;
            id_r   <= '0;
            op_r   <= OP_HOLD;
            mask_r <= '0;
            q      <= '0;
        end else begin
            if (state == IDLE && any) begin
                op_r   <= req_op[2*win +: 2];
                mask_r <= req_mask[WIDTH*win +: WIDTH];
                id_r   <= win;
                ptr    <= win == IDW'(N_REQ - 1) ? '0 : win + 1'b1;
            end
            if (state == APPLY) q <= q_nx;
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [1:0] jk;
        assign jk      = {op_r[1] & mask_r[b], op_r[0] & mask_r[b]};
        assign q_nx[b] = jk == OP_TGL ? ~q[b] :
                         jk == OP_SET ? 1'b1  :
                         jk == OP_CLR ? 1'b0  : q[b];
    end

endmodule

// File: tb/tb_jk_reg_arbiter.sv
// tb_jk_reg_arbiter: directed bench with a transaction-level model checked every cycle plus literal expectations.
module tb_jk_reg_arbiter;
    import jk_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op;
    logic [W*N-1:0] req_mask;
    logic           resp_valid;
    logic           resp_ready;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_q;
    logic [W-1:0]   q;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    jk_reg_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_mask   (req_mask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_q     (resp_q),
        .q          (q),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 waiting, 1 command accepted, 2 answer pending.
    int         m_phase = 0;
    int         m_ptr   = 0;
    int         m_id    = 0;
    logic [1:0] m_op    = 2'b00;
    logic [W-1:0] m_mask = '0;
    logic [W-1:0] m_q    = '0;
    int         cyc = 0;
    int         glog[$];
    int         gcyc[$];

    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic logic [W-1:0] apply_cmd(input logic [W-1:0] cur, input logic [1:0] o, input logic [W-1:0] m);
        case (o)
            OP_CLR:  return cur & ~m;
            OP_SET:  return cur | m;
            OP_TGL:  return cur ^ m;
            default: return cur;
        endcase
    endfunction

    always @(posedge clk) begin
        int w2;
        w2 = winner(req_valid, m_ptr);
        cyc <= cyc + 1;
        if (!rst) begin
            m_phase <= 0; m_q <= '0; m_ptr <= 0; m_id <= 0;
        end else if (m_phase == 0) begin
            if (w2 >= 0) begin
                m_op    <= req_op[2*w2 +: 2];
                m_mask  <= req_mask[W*w2 +: W];
                m_id    <= w2;
                m_ptr   <= (w2 + 1) % N;
                m_phase <= 1;
                glog.push_back(w2);
                gcyc.push_back(cyc);
            end
        end else if (m_phase == 1) begin
            m_q     <= apply_cmd(m_q, m_op, m_mask);
            m_phase <= 2;
        end else if (resp_ready) begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        int w;
        logic [N-1:0] e_ready;
        w = winner(req_valid, m_ptr);
        e_ready = (rst && m_phase == 0 && w >= 0) ? N'(1) << w : '0;
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("q", 32'(q), 32'(m_q));
        chk("resp_valid", 32'(resp_valid), 32'(m_phase == 2));
        if (m_phase == 2) begin
            chk("resp_id", 32'(resp_id), 32'(m_id));
            chk("resp_q", 32'(resp_q), 32'(m_q));
        end
    end

    task automatic cycle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] o, input logic [W-1:0] m);
        req_op[2*i +: 2] = o;
        req_mask[W*i +: W] = m;
    endtask

    // Leaves the DUT in RESP with the answer visible.
    task automatic issue(input int i, input logic [1:0] o, input logic [W-1:0] m);
        set_req(i, o, m);
        req_valid = N'(1) << i;
        cycle(1);
        req_valid = '0;
        cycle(1);
    endtask

    initial begin
        rst = 1'b0;
        resp_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < N; i++) set_req(i, OP_SET, W'(1) << i);
        cycle(2);
        chk("rst q", 32'(q), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst ready", 32'(req_ready), 32'h0);
        chk("rst resp_valid", 32'(resp_valid), 32'h0);
        chk("rst resp_id", 32'(resp_id), 32'h0);
        chk("rst resp_q", 32'(resp_q), 32'h0);

        rst = 1'b1;
        #1;
        chk("first grant", 32'(req_ready), 32'b0001);
        cycle(15);
        req_valid = '0;
        chk("rr count", 32'(glog.size()), 32'd5);
        for (int k = 0; k < 5; k++) chk($sformatf("rr order %0d", k), 32'(glog[k]), 32'(k % N));
        for (int k = 0; k < 4; k++) chk($sformatf("rr spacing %0d", k), 32'(gcyc[k+1] - gcyc[k]), 32'd3);
        chk("rr q", 32'(q), 32'h0F);

        issue(2, OP_CLR, 8'hFF);
        cycle(1);
        chk("clear q", 32'(q), 32'h00);

        set_req(1, OP_SET, 8'hF0);
        req_valid = 4'b0010;
        #1;
        chk("single ready", 32'(req_ready), 32'b0010);
        cycle(1);
        req_valid = '0;
        chk("apply q old", 32'(q), 32'h00);
        cycle(1);
        chk("set q", 32'(q), 32'hF0);
        chk("set resp_valid", 32'(resp_valid), 32'h1);
        chk("set resp_id", 32'(resp_id), 32'h1);
        chk("set resp_q", 32'(resp_q), 32'hF0);
        cycle(1);
        chk("idle busy", 32'(busy), 32'h0);

        issue(1, OP_TGL, 8'h3C);
        chk("tgl resp_q", 32'(resp_q), 32'hCC);
        chk("tgl resp_id", 32'(resp_id), 32'h1);
        cycle(1);

        resp_ready = 1'b0;
        issue(3, OP_SET, 8'h01);
        set_req(0, OP_HOLD, 8'hFF);
        req_valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            chk("bp resp_valid", 32'(resp_valid), 32'h1);
            chk("bp resp_id", 32'(resp_id), 32'h3);
            chk("bp resp_q", 32'(resp_q), 32'hCD);
            chk("bp ready", 32'(req_ready), 32'h0);
            chk("bp q", 32'(q), 32'hCD);
            cycle(1);
        end
        resp_ready = 1'b1;
        cycle(1);
        chk("wrap ready", 32'(req_ready), 32'b0001);
        cycle(1);
        req_valid = '0;
        cycle(1);
        chk("hold resp_id", 32'(resp_id), 32'h0);
        chk("hold resp_q", 32'(resp_q), 32'hCD);
        cycle(1);

        issue(3, OP_TGL, 8'h00);
        chk("zero mask resp_q", 32'(resp_q), 32'hCD);
        cycle(1);

        issue(2, OP_CLR, 8'hFF);
        cycle(1);
        issue(2, OP_SET, 8'hAA);
        cycle(1);
        chk("pre reset q", 32'(q), 32'hAA);
        set_req(1, OP_CLR, 8'hFF);
        req_valid = 4'b0010;
        cycle(1);
        req_valid = '0;
        rst = 1'b0;
        cycle(1);
        chk("mid rst q", 32'(q), 32'h0);
        chk("mid rst busy", 32'(busy), 32'h0);
        chk("mid rst resp_valid", 32'(resp_valid), 32'h0);
        rst = 1'b1;
        req_valid = 4'b1010;
        #1;
        chk("post rst ptr", 32'(req_ready), 32'b0010);
        cycle(1);
        req_valid = '0;
        cycle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
